// File: rtl/synth_pkg.sv
// Shared types and note_vol field positions for the voice envelope path.
package synth_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam int NV_GATE_BIT = 15;
  localparam int NV_NOTE_MSB = 14;
  localparam int NV_NOTE_LSB = 8;
  localparam int NV_VEL_W    = 8;
  localparam int NV_NOTE_W   = NV_NOTE_MSB - NV_NOTE_LSB + 1;

endpackage

// File: rtl/adsr_envelope_if.sv
// note_vol bus between the NIOS PIO side and one voice envelope, plus debug taps.
interface adsr_envelope_if;
  import synth_pkg::*;

  logic [15:0] note_vol_in;
  logic [15:0] note_vol_out;
  logic [15:0] env_level;
  logic        active;
  env_state_t  env_state;

  modport master (output note_vol_in,
                  input  note_vol_out, env_level, active, env_state);
  modport slave  (input  note_vol_in,
                  output note_vol_out, env_level, active, env_state);
endinterface

// File: rtl/adsr_envelope_sample_tick_sync.sv
// Brings LRCLK into the clk domain and emits a one-clk pulse per rising edge.
module sample_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);
  logic [2:0] sync_q, sync_d;
  logic       tick_q, tick_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
    tick_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
      tick_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: decodes gate/note/velocity, steps the envelope once per
// audio sample and re-emits note_vol with volume scaled by the envelope.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter logic [15:0] ATTACK_STEP   = 16'h0400,
  parameter logic [15:0] DECAY_STEP    = 16'h0040,
  parameter logic [15:0] SUSTAIN_LEVEL = 16'hA000,
  parameter logic [15:0] RELEASE_STEP  = 16'h0080
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sample_clock,
  adsr_envelope_if.slave  bus
);

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [15:0] sub_floor(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] floor_v);
    logic [16:0] d;
    d = {1'b0, a} - {1'b0, b};
    return (d[16] || (d[15:0] < floor_v)) ? floor_v : d[15:0];
  endfunction

  function automatic logic [NV_VEL_W-1:0] scale_vol(input logic [NV_VEL_W-1:0] vel,
                                                    input logic [7:0] lvl);
    logic [15:0] p;
    p = 16'(vel) * 16'(lvl);
    return p[15:8];
  endfunction

  logic                 tick;
  logic [15:0]          nv_q, nv_d, nv_prev_q, nv_prev_d;
  logic                 armed_q, armed_d;
  logic                 gate_rise, gate_fall, retrig;
  env_state_t           state_q, state_d;
  logic [15:0]          env_q, env_d;
  logic [NV_NOTE_W-1:0] note_q, note_d;
  logic [NV_VEL_W-1:0]  vel_q, vel_d;
  logic [15:0]          out_q, out_d;
  logic                 active_q, active_d;

  sample_tick_sync u_tick (
    .clk      (clk),
    .rst_n    (reset_n),
    .async_in (sample_clock),
    .tick     (tick)
  );

  // armed only after a low gate has been seen, so a gate held high through reset cannot start a note
  always_comb begin
    nv_d      = bus.note_vol_in;
    nv_prev_d = nv_q;
    armed_d   = armed_q | ~bus.note_vol_in[NV_GATE_BIT];
    gate_rise = armed_q & nv_q[NV_GATE_BIT] & ~nv_prev_q[NV_GATE_BIT];
    gate_fall = armed_q & ~nv_q[NV_GATE_BIT] & nv_prev_q[NV_GATE_BIT];
    retrig    = armed_q & nv_q[NV_GATE_BIT] & nv_prev_q[NV_GATE_BIT] &
                (nv_q[NV_NOTE_MSB:NV_NOTE_LSB] != nv_prev_q[NV_NOTE_MSB:NV_NOTE_LSB]);
  end

  // gate events take priority over the envelope step on the same clk
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    note_d  = note_q;
    vel_d   = vel_q;
    if (gate_rise || retrig) begin
      state_d = ATTACK;
      note_d  = nv_q[NV_NOTE_MSB:NV_NOTE_LSB];
      vel_d   = nv_q[NV_VEL_W-1:0];
    end else if (gate_fall && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
      state_d = RELEASE;
    end else if (tick) begin
      case (state_q)
        ATTACK: begin
          env_d = sat_add(env_q, ATTACK_STEP);
          if (env_d == 16'hFFFF) state_d = DECAY;
        end
        DECAY: begin
          env_d = sub_floor(env_q, DECAY_STEP, SUSTAIN_LEVEL);
          if (env_d == SUSTAIN_LEVEL) state_d = SUSTAIN;
        end
        RELEASE: begin
          env_d = sub_floor(env_q, RELEASE_STEP, 16'h0000);
          if (env_d == 16'h0000) state_d = IDLE;
        end
        default: ;
      endcase
    end
    active_d = (state_d != IDLE);
    out_d    = (state_q == IDLE) ? 16'h0000
                                 : {1'b1, note_q, scale_vol(vel_q, env_q[15:8])};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nv_q      <= 16'h0000;
      nv_prev_q <= 16'h0000;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      env_q     <= 16'h0000;
      note_q    <= '0;
      vel_q     <= '0;
      out_q     <= 16'h0000;
      active_q  <= 1'b0;
    end else begin
      nv_q      <= nv_d;
      nv_prev_q <= nv_prev_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      env_q     <= env_d;
      note_q    <= note_d;
      vel_q     <= vel_d;
      out_q     <= out_d;
      active_q  <= active_d;
    end
  end

  assign bus.note_vol_out = out_q;
  assign bus.env_level    = env_q;
  assign bus.active       = active_q;
  assign bus.env_state    = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed ADSR walk-through plus random gate/note traffic.
module tb_adsr_envelope;

  localparam int AS = 32'h4000;
  localparam int DS = 32'h1000;
  localparam int SL = 32'hC000;
  localparam int RS = 32'h8000;

  logic clk;
  logic reset_n;
  logic sample_clock;
  adsr_envelope_if bus ();

  adsr_envelope #(
    .ATTACK_STEP   (16'h4000),
    .DECAY_STEP    (16'h1000),
    .SUSTAIN_LEVEL (16'hC000),
    .RELEASE_STEP  (16'h8000)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_clock (sample_clock),
    .bus          (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    sample_clock = 1'b0;
    #3;
    forever #320 sample_clock = ~sample_clock;
  end

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state 0..4 = IDLE, ATTACK, DECAY, SUSTAIN, RELEASE
  int          m_state = 0;
  int          m_env = 0;
  int          m_note = 0;
  int          m_vel = 0;
  logic [15:0] m_out = 16'h0000;
  int          tick_cnt = 0;
  bit          seen_low = 1'b0;
  bit          sc_h[$];
  logic [15:0] nv_h[$];
  int          n, nn, vol;
  bit          tk, rise, fall, rtg, have2;
  logic [15:0] cur, prv;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0; m_env = 0; m_note = 0; m_vel = 0; m_out = 16'h0000;
      seen_low = 1'b0;
      sc_h.delete();
      nv_h.delete();
    end else begin
      n  = sc_h.size();
      tk = (n >= 3 && sc_h[n-3]) && !(n >= 4 && sc_h[n-4]);
      vol = (m_vel * (m_env / 256)) / 256;
      m_out = (m_state == 0) ? 16'h0000 : {1'b1, 7'(m_note), 8'(vol)};
      nn = nv_h.size();
      have2 = (nn >= 2);
      cur = have2 ? nv_h[nn-1] : 16'h0000;
      prv = have2 ? nv_h[nn-2] : 16'h0000;
      rise = have2 && cur[15] && !prv[15];
      fall = have2 && !cur[15] && prv[15];
      rtg  = have2 && seen_low && cur[15] && prv[15] && (cur[14:8] != prv[14:8]);
      if (tk) tick_cnt++;
      if (rise || rtg) begin
        m_state = 1; m_note = int'(cur[14:8]); m_vel = int'(cur[7:0]);
      end else if (fall && (m_state >= 1) && (m_state <= 3)) begin
        m_state = 4;
      end else if (tk) begin
        case (m_state)
          1: begin
            m_env = (m_env + AS > 65535) ? 65535 : m_env + AS;
            if (m_env == 65535) m_state = 2;
          end
          2: begin
            m_env = (m_env - DS < SL) ? SL : m_env - DS;
            if (m_env == SL) m_state = 3;
          end
          4: begin
            m_env = (m_env - RS < 0) ? 0 : m_env - RS;
            if (m_env == 0) m_state = 0;
          end
          default: ;
        endcase
      end
      sc_h.push_back(sample_clock);
      nv_h.push_back(bus.note_vol_in);
      if (!bus.note_vol_in[15]) seen_low = 1'b1;
      while (sc_h.size() > 6) void'(sc_h.pop_front());
      while (nv_h.size() > 6) void'(nv_h.pop_front());
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_env",    32'(bus.env_level),    32'(m_env));
      chk("cyc_state",  32'(bus.env_state),    32'(m_state));
      chk("cyc_active", 32'(bus.active),       32'(m_state != 0));
      chk("cyc_out",    32'(bus.note_vol_out), 32'(m_out));
    end
  end

  task automatic wait_tick();
    int start;
    int k;
    start = tick_cnt;
    k = 0;
    while (tick_cnt == start && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (tick_cnt == start) chk("tick_timeout", 32'(k), 32'(0));
    @(negedge clk);
  endtask

  task automatic reset_pulse(input int hold);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_env",    32'(bus.env_level),    32'h0);
    chk("rst_state",  32'(bus.env_state),    32'h0);
    chk("rst_out",    32'(bus.note_vol_out), 32'h0);
    chk("rst_active", 32'(bus.active),       32'h0);
    repeat (hold) @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  logic [15:0] atk_exp [4];
  logic [15:0] dec_exp [4];
  int r;

  initial begin
    atk_exp[0] = 16'h4000; atk_exp[1] = 16'h8000; atk_exp[2] = 16'hC000; atk_exp[3] = 16'hFFFF;
    dec_exp[0] = 16'hEFFF; dec_exp[1] = 16'hDFFF; dec_exp[2] = 16'hCFFF; dec_exp[3] = 16'hC000;
    reset_n = 1'b0;
    bus.note_vol_in = 16'h8000;
    repeat (5) @(negedge clk);
    cmp_en = 1'b1;
    #2 reset_n = 1'b1;

    // gate held high across reset must not start a note
    repeat (200) @(negedge clk);
    chk("t1_state", 32'(bus.env_state), 32'h0);
    chk("t1_env",   32'(bus.env_level), 32'h0);
    chk("t1_out",   32'(bus.note_vol_out), 32'h0);

    bus.note_vol_in = 16'h0000;
    wait_tick();
    bus.note_vol_in = 16'hBC7F;
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      chk($sformatf("t2_atk%0d", i + 1), 32'(bus.env_level), 32'(atk_exp[i]));
    end
    chk("t2_state_decay", 32'(bus.env_state), 32'h2);
    chk("t2_out_peak",    32'(bus.note_vol_out), 32'hBC7E);

    for (int i = 0; i < 4; i++) begin
      wait_tick();
      chk($sformatf("t3_dec%0d", i + 5), 32'(bus.env_level), 32'(dec_exp[i]));
    end
    chk("t3_state_sus", 32'(bus.env_state), 32'h3);
    chk("t3_out_sus",   32'(bus.note_vol_out), 32'hBC5F);
    wait_tick();
    chk("t3_sus_hold",  32'(bus.env_level), 32'hC000);

    bus.note_vol_in = 16'h3C7F;
    repeat (3) @(negedge clk);
    chk("t4_state_rel", 32'(bus.env_state), 32'h4);
    chk("t4_out_rel",   32'(bus.note_vol_out), 32'hBC5F);
    wait_tick();
    chk("t4_env_4000",  32'(bus.env_level), 32'h4000);
    chk("t4_out_4000",  32'(bus.note_vol_out), 32'hBC1F);
    wait_tick();
    chk("t4_env_0",     32'(bus.env_level), 32'h0);
    chk("t4_state_idle", 32'(bus.env_state), 32'h0);
    chk("t4_out_0",     32'(bus.note_vol_out), 32'h0);

    bus.note_vol_in = 16'hBC7F;
    wait_tick();
    wait_tick();
    chk("t5_env_8000", 32'(bus.env_level), 32'h8000);
    bus.note_vol_in = 16'hC07F;
    repeat (3) @(negedge clk);
    chk("t5_retrig_state", 32'(bus.env_state), 32'h1);
    chk("t5_retrig_env",   32'(bus.env_level), 32'h8000);
    chk("t5_retrig_out",   32'(bus.note_vol_out), 32'hC03F);
    wait_tick();
    chk("t5_env_c000", 32'(bus.env_level), 32'hC000);
    // land the next retrigger on the same clk as the following tick
    repeat (61) @(negedge clk);
    bus.note_vol_in = 16'hC27F;
    wait_tick();
    chk("t5_skip_env",   32'(bus.env_level), 32'hC000);
    chk("t5_skip_state", 32'(bus.env_state), 32'h1);
    wait_tick();
    chk("t5_env_ffff",   32'(bus.env_level), 32'hFFFF);

    bus.note_vol_in = 16'h427F;
    wait_tick();
    chk("t6_rel_env", 32'(bus.env_level), 32'h7FFF);
    reset_pulse(5);

    for (int it = 0; it < 200; it++) begin
      repeat ($urandom_range(1, 150)) @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 4) begin
        reset_pulse($urandom_range(1, 8));
      end else if (r < 40) begin
        bus.note_vol_in = bus.note_vol_in ^ 16'h8000;
      end else if (r < 65) begin
        bus.note_vol_in = {bus.note_vol_in[15], 7'($urandom), bus.note_vol_in[7:0]};
      end else begin
        bus.note_vol_in = 16'($urandom);
      end
    end
    repeat (400) @(negedge clk);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
